// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial link: word width, serializer
// states and receiver states.
package serial_pkg;

    localparam int unsigned WORD_W = 8;

    // Serializer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } ser_state_t;

    // Receiver FSM states (deserializer side of the link)
    typedef enum logic {
        READING = 1'b0,
        WAITING = 1'b1
    } rx_state_t;

endpackage

// File: rtl/serial_hold_reg.sv
// One-entry holding buffer between the word producer and the shifter.
// Ports:
//   clock_100KHz, reset   clock and async active-high reset
//   data_in               word captured on load
//   load                  producer handshake completed this edge
//   unload                shifter takes the buffered word this edge
//   data_out              buffered word
//   full                  buffer holds a word
//   full_nxt_c            value full takes on the coming edge
//   ready_out             registered !full; low during the cycle after reset
module serial_hold_reg
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH = WORD_W
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    input  logic             unload,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             full_nxt_c,
    output logic             ready_out
);

    // A load on the same edge as an unload keeps the buffer occupied
    assign full_nxt_c = load || (full && !unload);

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            full      <= 1'b0;
            ready_out <= 1'b0;
        end else begin
            if (load) begin
                data_out <= data_in;
            end
            full      <= full_nxt_c;
            ready_out <= !full_nxt_c;
        end
    end

endmodule

// File: rtl/serializador.sv
// Transmit end of the bit-serial link: takes words from a producer and
// shifts them out one bit per transfer. A transfer happens on each edge
// where write_out and status_in are both high.
// Ports:
//   clock_100KHz, reset   clock and async active-high reset
//   data_in, valid_in     producer word and its valid flag
//   ready_out             holding register empty (accept on valid_in && ready_out)
//   bit_out, write_out    serial bit and its valid flag to the receiver
//   status_in             receiver can accept a bit
//   word_sent             one-cycle pulse after the last bit of a word transfers
//   busy_out              shifting or holding a word
module serializador
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = WORD_W,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clock_100KHz,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             bit_out,
    output logic             write_out,
    input  logic             status_in,
    output logic             word_sent,
    output logic             busy_out
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    ser_state_t       state;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             hold_full_nxt_c;
    logic             load_c;
    logic             unload_c;
    logic             last_c;
    logic             shift_nxt_c;

    // Bit of a word that goes out at position idx of the serial sequence
    function automatic logic pick_bit(input logic [WIDTH-1:0] word,
                                      input logic [CNT_W-1:0] idx);
        logic [CNT_W-1:0] pos;
        pos = LSB_FIRST ? idx : (CNT_W'(WIDTH - 1) - idx);
        return word[pos[IDX_W-1:0]];
    endfunction

    assign load_c   = valid_in && ready_out;
    assign last_c   = (count == CNT_W'(WIDTH - 1));
    // Buffer drains into the shifter when idle, or when the last bit of
    // the current word transfers
    assign unload_c = hold_full &&
                      ((state == IDLE) || ((state == SHIFT) && status_in && last_c));

    // Whether the FSM will be in SHIFT after the coming edge
    always_comb begin
        shift_nxt_c = 1'b0;
        case (state)
            IDLE:    shift_nxt_c = hold_full;
            SHIFT:   shift_nxt_c = !(status_in && last_c && !hold_full);
            default: shift_nxt_c = 1'b0;
        endcase
    end

    serial_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .data_in      (data_in),
        .load         (load_c),
        .unload       (unload_c),
        .data_out     (hold_data),
        .full         (hold_full),
        .full_nxt_c   (hold_full_nxt_c),
        .ready_out    (ready_out)
    );

    // Shifter FSM; status_in low in SHIFT stalls everything in place
    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            count     <= '0;
            bit_out   <= 1'b0;
            write_out <= 1'b0;
            word_sent <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            word_sent <= 1'b0;
            busy_out  <= shift_nxt_c || hold_full_nxt_c;
            case (state)
                IDLE: begin
                    write_out <= 1'b0;
                    if (hold_full) begin
                        shift_reg <= hold_data;
                        count     <= '0;
                        bit_out   <= pick_bit(hold_data, CNT_W'(0));
                        write_out <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (status_in) begin
                        if (last_c) begin
                            word_sent <= 1'b1;
                            count     <= '0;
                            if (hold_full) begin
                                // Reload with no gap in write_out
                                shift_reg <= hold_data;
                                bit_out   <= pick_bit(hold_data, CNT_W'(0));
                            end else begin
                                write_out <= 1'b0;
                                state     <= IDLE;
                            end
                        end else begin
                            count   <= count + CNT_W'(1);
                            bit_out <= pick_bit(shift_reg, count + CNT_W'(1));
                        end
                    end
                end
                default: begin
                    write_out <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializador.sv
// Directed bench for serializador: an LSB-first instance and an MSB-first
// instance share all inputs; a small receiver model closes the loop.
module tb_serializador;
    import serial_pkg::*;

    logic       clock_100KHz = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       tb_status;
    logic       loop_mode;
    logic       status_in;

    logic ready_out, bit_out, write_out, word_sent, busy_out;
    logic ready_m, bit_m, write_m, sent_m, busy_m;

    // Receiver model
    rx_state_t  rx_state;
    logic [2:0] rx_cnt;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       ack_in;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    bit cap_q[$];
    int cap_cyc[$];
    bit cap_m[$];
    int ws_cyc[$];

    always #5 clock_100KHz = ~clock_100KHz;

    assign status_in = loop_mode ? (rx_state == READING) : tb_status;

    serializador #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .bit_out      (bit_out),
        .write_out    (write_out),
        .status_in    (status_in),
        .word_sent    (word_sent),
        .busy_out     (busy_out)
    );

    serializador #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .ready_out    (ready_m),
        .bit_out      (bit_m),
        .write_out    (write_m),
        .status_in    (status_in),
        .word_sent    (sent_m),
        .busy_out     (busy_m)
    );

    always @(posedge clock_100KHz) cycle <= cycle + 1;

    // Receiver: fills data_out[count], then waits for ack with status low
    always @(posedge clock_100KHz or posedge reset) begin
        if (reset || !loop_mode) begin
            rx_state   <= READING;
            rx_cnt     <= 3'd0;
            rx_data    <= 8'h00;
            data_ready <= 1'b0;
        end else begin
            case (rx_state)
                READING: begin
                    if (write_out && status_in) begin
                        rx_data[rx_cnt] <= bit_out;
                        if (rx_cnt == 3'd7) begin
                            rx_state   <= WAITING;
                            data_ready <= 1'b1;
                            rx_cnt     <= 3'd0;
                        end else begin
                            rx_cnt <= rx_cnt + 3'd1;
                        end
                    end
                end
                WAITING: begin
                    if (ack_in) begin
                        rx_state   <= READING;
                        data_ready <= 1'b0;
                    end
                end
                default: rx_state <= READING;
            endcase
        end
    end

    // Record each transfer that the coming rising edge will perform
    always @(negedge clock_100KHz) begin
        if (!reset) begin
            if (write_out && status_in) begin
                cap_q.push_back(bit_out);
                cap_cyc.push_back(cycle);
            end
            if (write_m && status_in) cap_m.push_back(bit_m);
            if (word_sent) ws_cyc.push_back(cycle);
        end
    end

    task automatic tick();
        @(posedge clock_100KHz);
        #1;
    endtask

    task automatic clear_caps();
        cap_q.delete();
        cap_cyc.delete();
        cap_m.delete();
        ws_cyc.delete();
    endtask

    // Present a word and return just after the edge that accepts it
    task automatic send_word(input logic [7:0] w);
        bit ok = 1'b0;
        data_in  = w;
        valid_in = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock_100KHz);
            if (ready_out) begin
                @(posedge clock_100KHz);
                #1;
                ok = 1'b1;
            end
        end
        valid_in = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_word: ready_out never high for word %h", w);
        end
    endtask

    task automatic wait_sent(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock_100KHz);
            #1;
            if (ws_cyc.size() >= n) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_sent: got %0d word_sent pulses, need %0d", ws_cyc.size(), n);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        valid_in  = 1'b0;
        data_in   = 8'h00;
        tb_status = 1'b1;
        loop_mode = 1'b0;
        ack_in    = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ready_out, bit_out, write_out, word_sent, busy_out} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b need 00000",
                     {ready_out, bit_out, write_out, word_sent, busy_out});
        end
        checks++;
        if ({ready_m, bit_m, write_m, sent_m, busy_m} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_msb: got %b need 00000",
                     {ready_m, bit_m, write_m, sent_m, busy_m});
        end
        reset = 1'b0;
        @(negedge clock_100KHz);
        checks++;
        if (ready_out !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_edge: got %b need 0", ready_out);
        end
        tick();
        checks++;
        if (ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_first_edge: ready %b busy %b need 1 0", ready_out, busy_out);
        end
    endtask

    task automatic test_single();
        logic [7:0] w = 8'hA5;
        int bad = 0;
        clear_caps();
        tb_status = 1'b1;
        send_word(w);
        checks++;
        if (write_out !== 1'b0 || busy_out !== 1'b1) begin
            errors++;
            $display("FAIL accept_edge: write_out %b busy %b need 0 1", write_out, busy_out);
        end
        tick();
        checks++;
        if (write_out !== 1'b1 || bit_out !== 1'b1) begin
            errors++;
            $display("FAIL latency2: write_out %b bit_out %b need 1 1", write_out, bit_out);
        end
        wait_sent(1);
        repeat (2) tick();
        checks++;
        if (cap_q.size() != 8) begin
            errors++;
            $display("FAIL a5_count: got %0d transfers need 8", cap_q.size());
        end else begin
            for (int i = 0; i < 8; i++) if (cap_q[i] !== w[3'(i)]) bad++;
            if (bad != 0) begin
                errors++;
                $display("FAIL a5_bits: %0d bits differ from 1,0,1,0,0,1,0,1", bad);
            end
        end
        checks++;
        if (ws_cyc.size() != 1 || write_out !== 1'b0 || ready_out !== 1'b1 || busy_out !== 1'b0) begin
            errors++;
            $display("FAIL a5_end: pulses %0d write_out %b ready %b busy %b need 1 0 1 0",
                     ws_cyc.size(), write_out, ready_out, busy_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0 = 8'h3C;
        logic [7:0] w1 = 8'hC3;
        logic [7:0] g0 = 8'h00;
        logic [7:0] g1 = 8'h00;
        clear_caps();
        tb_status = 1'b1;
        send_word(w0);
        send_word(w1);
        wait_sent(2);
        repeat (2) tick();
        checks++;
        if (cap_q.size() != 16) begin
            errors++;
            $display("FAIL b2b_count: got %0d transfers need 16", cap_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                g0[3'(i)] = cap_q[i];
                g1[3'(i)] = cap_q[i + 8];
            end
            checks++;
            if (g0 !== w0 || g1 !== w1) begin
                errors++;
                $display("FAIL b2b_words: got %h %h need %h %h", g0, g1, w0, w1);
            end
            checks++;
            if (cap_cyc[15] - cap_cyc[0] != 15) begin
                errors++;
                $display("FAIL b2b_gap: 16 transfers span %0d cycles need 15", cap_cyc[15] - cap_cyc[0]);
            end
        end
        checks++;
        if (ws_cyc.size() != 2) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses need 2", ws_cyc.size());
        end else if (ws_cyc[1] - ws_cyc[0] != 8) begin
            errors++;
            $display("FAIL b2b_pulses: spacing %0d need 8", ws_cyc[1] - ws_cyc[0]);
        end
    endtask

    task automatic test_stall();
        logic [7:0] w   = 8'hF0;
        logic [3:0] pat = 4'b1001;
        logic [7:0] got = 8'h00;
        int ntrans = 0;
        clear_caps();
        tb_status = 1'b1;
        send_word(w);
        for (int i = 0; i < 80 && ntrans < 8; i++) begin
            tb_status = pat[2'(i % 4)];
            @(negedge clock_100KHz);
            #1;
            if (write_out) begin
                checks++;
                if (bit_out !== w[3'(ntrans)]) begin
                    errors++;
                    $display("FAIL stall_bit: index %0d status %b got %b need %b",
                             ntrans, status_in, bit_out, w[3'(ntrans)]);
                end
                if (status_in) ntrans++;
            end
            @(posedge clock_100KHz);
            #1;
        end
        tb_status = 1'b1;
        repeat (3) tick();
        checks++;
        if (ntrans != 8 || cap_q.size() != 8) begin
            errors++;
            $display("FAIL stall_count: got %0d/%0d transfers need 8", ntrans, cap_q.size());
        end else begin
            for (int i = 0; i < 8; i++) got[3'(i)] = cap_q[i];
            checks++;
            if (got !== w) begin
                errors++;
                $display("FAIL stall_word: got %h need %h", got, w);
            end
        end
        checks++;
        if (ws_cyc.size() != 1 || write_out !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: pulses %0d write_out %b need 1 0", ws_cyc.size(), write_out);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] w   = 8'h7E;
        logic [7:0] got = 8'h00;
        bit ok = 1'b0;
        clear_caps();
        tb_status = 1'b1;
        send_word(8'h81);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clock_100KHz);
            #1;
            if (cap_q.size() >= 3) ok = 1'b1;
        end
        @(posedge clock_100KHz);
        #1;
        reset = 1'b1;
        @(negedge clock_100KHz);
        checks++;
        if (!ok || {ready_out, bit_out, write_out, word_sent, busy_out} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: reached3 %b got %b need 00000",
                     ok, {ready_out, bit_out, write_out, word_sent, busy_out});
        end
        repeat (2) tick();
        reset = 1'b0;
        tick();
        clear_caps();
        send_word(w);
        wait_sent(1);
        repeat (2) tick();
        checks++;
        if (cap_q.size() != 8) begin
            errors++;
            $display("FAIL midreset_count: got %0d transfers need 8", cap_q.size());
        end else begin
            for (int i = 0; i < 8; i++) got[3'(i)] = cap_q[i];
            checks++;
            if (got !== w) begin
                errors++;
                $display("FAIL midreset_word: got %h need %h", got, w);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [3] = '{8'h00, 8'hFF, 8'h55};
        clear_caps();
        loop_mode = 1'b1;
        ack_in    = 1'b0;
        fork
            begin
                for (int k = 0; k < 3; k++) send_word(words[k]);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    bit ok = 1'b0;
                    logic [7:0] nxt;
                    for (int j = 0; j < 300 && !ok; j++) begin
                        @(negedge clock_100KHz);
                        if (data_ready) ok = 1'b1;
                    end
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL loop_ready: word %0d data_ready timeout", k);
                    end else if (rx_data !== words[k]) begin
                        errors++;
                        $display("FAIL loop_word: word %0d got %h need %h", k, rx_data, words[k]);
                    end
                    if (ok && k < 2) begin
                        nxt = words[k + 1];
                        checks++;
                        if (write_out !== 1'b1 || bit_out !== nxt[0] || status_in !== 1'b0) begin
                            errors++;
                            $display("FAIL loop_waiting: write_out %b bit_out %b status %b need 1 %b 0",
                                     write_out, bit_out, status_in, nxt[0]);
                        end
                    end
                    @(posedge clock_100KHz);
                    @(posedge clock_100KHz);
                    #1;
                    ack_in = 1'b1;
                    tick();
                    ack_in = 1'b0;
                end
            end
        join
        repeat (3) tick();
        checks++;
        if (write_out !== 1'b0 || busy_out !== 1'b0 || cap_q.size() != 24) begin
            errors++;
            $display("FAIL loop_end: write_out %b busy %b transfers %0d need 0 0 24",
                     write_out, busy_out, cap_q.size());
        end
        loop_mode = 1'b0;
        tick();
    endtask

    task automatic test_msb();
        logic [7:0] w    = 8'hA0;
        logic [7:0] gotm = 8'h00;
        logic [7:0] gotl = 8'h00;
        clear_caps();
        tb_status = 1'b1;
        send_word(w);
        wait_sent(1);
        repeat (2) tick();
        checks++;
        if (cap_m.size() != 8 || cap_q.size() != 8) begin
            errors++;
            $display("FAIL msb_count: got %0d/%0d transfers need 8", cap_m.size(), cap_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                gotm = {gotm[6:0], cap_m[i]};
                gotl[3'(i)] = cap_q[i];
            end
            checks++;
            if (gotm !== w) begin
                errors++;
                $display("FAIL msb_order: got %h need %h (1,0,1,0,0,0,0,0)", gotm, w);
            end
            checks++;
            if (gotl !== w || cap_q[0] !== 1'b0 || cap_m[0] !== 1'b1) begin
                errors++;
                $display("FAIL lsb_vs_msb: lsb word %h first %b/%b need %h first 0/1",
                         gotl, cap_q[0], cap_m[0], w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_loopback();
        test_msb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
